pll_supervisor: RTL

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor_pkg.sv | 21 ++
 rtl/pll_supervisor_if.sv | 24 ++
 rtl/sync_2ff.sv | 14 +
 rtl/pll_supervisor.sv | 89 ++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg: shared state encoding, default timing constants and helpers
// for the PLL reset/lock supervisor.
package pll_supervisor_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int CNT_W                   = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: lock input and reset/status outputs of the PLL supervisor,
// with a supervisor-side and a consumer-side view.
interface pll_supervisor_if;
    import pll_supervisor_pkg::*;

    logic             pll_locked;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             lost_lock;
    logic [CNT_W-1:0] relock_count;
    logic [CNT_W-1:0] timeout_count;

    modport master (
        input  pll_locked,
        output pll_rst, sys_rst, ready, lost_lock, relock_count, timeout_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst, sys_rst, ready, lost_lock, relock_count, timeout_count
    );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk)
        sync_q <= rst ? 2'b00 : {sync_q[0], d_i};

    assign q_o = sync_q[1];
endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: holds the PLL in reset, waits for a qualified lock, then releases
// the system reset; re-arms on lock loss or lock timeout and counts both events.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             lost_lock,
    output logic [CNT_W-1:0] relock_count,
    output logic [CNT_W-1:0] timeout_count
);
    localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW    = $clog2(MAX_P);

    logic             lk_s;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [CNT_W-1:0] relock_q, relock_d, tmo_q, tmo_d;
    logic             lost_q, lost_d;

    sync_2ff u_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (lk_s)
    );

    // cycle counter restarts on every state change and idles at zero in RUN
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= RESET_PLL;
            cnt_q    <= '0;
            relock_q <= '0;
            tmo_q    <= '0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= (state_d != state_q || state_q == RUN) ? '0 : cnt_q + 1'b1;
            relock_q <= relock_d;
            tmo_q    <= tmo_d;
            lost_q   <= lost_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        relock_d = relock_q;
        tmo_d    = tmo_q;
        lost_d   = 1'b0;
        unique case (state_q)
            RESET_PLL: state_d = (cnt_q == CW'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: begin
                // a lock seen on the timeout cycle wins over the retry
                if (lk_s) begin
                    state_d = STABILIZE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    state_d = RESET_PLL;
                    tmo_d   = sat_inc(tmo_q);
                end
            end
            STABILIZE: state_d = !lk_s ? WAIT_LOCK :
                                 (cnt_q == CW'(LOCK_STABLE_CYCLES - 1)) ? RUN : STABILIZE;
            RUN: begin
                if (!lk_s) begin
                    state_d  = WAIT_LOCK;
                    relock_d = sat_inc(relock_q);
                    lost_d   = 1'b1;
                end
            end
            default: state_d = RESET_PLL;
        endcase
    end

    assign pll_rst       = (state_q == RESET_PLL);
    assign sys_rst       = (state_q != RUN);
    assign ready         = (state_q == RUN);
    assign lost_lock     = lost_q;
    assign relock_count  = relock_q;
    assign timeout_count = tmo_q;
endmodule
